// File: rtl/dmem_ctrl_pkg.sv
// Shared constants for the data-memory controller: RV32I load/store funct3 codes,
// FSM state encoding and access-size decode.
package dmem_ctrl_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      DM_IDLE = 2'd0,
      DM_REQ  = 2'd1,
      DM_RESP = 2'd2
   } dm_state_e;

   typedef enum logic [1:0] {
      SzByte = 2'd0,
      SzHalf = 2'd1,
      SzWord = 2'd2
   } size_e;

   // Reserved encodings fall through to a word access.
   function automatic size_e f3_size(input logic [2:0] f3);
      case (f3)
         F3_B, F3_BU: f3_size = SzByte;
         F3_H, F3_HU: f3_size = SzHalf;
         default:     f3_size = SzWord;
      endcase
   endfunction

endpackage

// File: rtl/dmem_lane.sv
// Combinational lane logic: store replication and byte enables, alignment check,
// and load shift with sign/zero extension.
module dmem_lane
   import dmem_ctrl_pkg::*;
(
   input  logic [2:0]  st_funct3,
   input  logic [1:0]  st_off,
   input  logic        st_we,
   input  logic [31:0] st_wdata,
   output logic [3:0]  st_be,
   output logic [31:0] st_wdata_rep,
   output logic        aligned,
   input  logic [2:0]  ld_funct3,
   input  logic [1:0]  ld_off,
   input  logic [31:0] ld_rdata,
   output logic [31:0] ld_data
);

   size_e       st_size;
   size_e       ld_size;
   logic [31:0] ld_shifted;
   logic        ld_sext;

   always_comb begin
      st_size      = f3_size(st_funct3);
      st_be        = 4'b1111;
      st_wdata_rep = st_wdata;
      aligned      = 1'b1;
      case (st_size)
         SzByte: begin
            st_be        = 4'b0001 << st_off;
            st_wdata_rep = {4{st_wdata[7:0]}};
         end
         SzHalf: begin
            st_be        = 4'b0011 << {st_off[1], 1'b0};
            st_wdata_rep = {2{st_wdata[15:0]}};
            aligned      = ~st_off[0];
         end
         default: begin
            aligned = (st_off == 2'b00);
         end
      endcase
      if (!st_we) begin
         st_be = 4'b0000;
      end
   end

   always_comb begin
      ld_size    = f3_size(ld_funct3);
      ld_shifted = ld_rdata >> {ld_off, 3'b000};
      ld_sext    = ~ld_funct3[2];
      case (ld_size)
         SzByte:  ld_data = {{24{ld_sext & ld_shifted[7]}}, ld_shifted[7:0]};
         SzHalf:  ld_data = {{16{ld_sext & ld_shifted[15]}}, ld_shifted[15:0]};
         default: ld_data = ld_shifted;
      endcase
   end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: one load/store per instruction to a variable-latency SRAM,
// stalling the core while the access is outstanding.
module dmem_ctrl
   import dmem_ctrl_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned TIMEOUT    = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   input  logic                  req_we,
   input  logic [2:0]            req_funct3,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic [DATA_WIDTH-1:0] resp_rdata,
   output logic                  stall,
   output logic                  misalign,
   output logic                  bus_err,
   output logic                  sram_en,
   output logic [3:0]            sram_be,
   output logic [ADDR_WIDTH-3:0] sram_addr,
   output logic [DATA_WIDTH-1:0] sram_wdata,
   input  logic [DATA_WIDTH-1:0] sram_rdata,
   input  logic                  sram_ready
);

   localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

   dm_state_e   state_q;
   logic [7:0]  cnt_q;
   logic [2:0]  ld_funct3_q;
   logic [1:0]  ld_off_q;

   logic [3:0]  lane_be;
   logic [31:0] lane_wdata;
   logic [31:0] lane_rdata;
   logic        aligned;

   dmem_lane u_lane (
      .st_funct3    (req_funct3),
      .st_off       (req_addr[1:0]),
      .st_we        (req_we),
      .st_wdata     (req_wdata),
      .st_be        (lane_be),
      .st_wdata_rep (lane_wdata),
      .aligned      (aligned),
      .ld_funct3    (ld_funct3_q),
      .ld_off       (ld_off_q),
      .ld_rdata     (sram_rdata),
      .ld_data      (lane_rdata)
   );

   // Combinational so the core freezes in the very cycle the request appears.
   assign stall = rst_n & (((state_q == DM_IDLE) & req_valid & aligned) | (state_q == DM_REQ));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= DM_IDLE;
         cnt_q       <= '0;
         ld_funct3_q <= '0;
         ld_off_q    <= '0;
         sram_en     <= 1'b0;
         sram_be     <= '0;
         sram_addr   <= '0;
         sram_wdata  <= '0;
         resp_rdata  <= '0;
         misalign    <= 1'b0;
         bus_err     <= 1'b0;
      end else begin
         misalign <= 1'b0;
         bus_err  <= 1'b0;
         case (state_q)
            DM_IDLE: begin
               if (req_valid) begin
                  if (aligned) begin
                     state_q     <= DM_REQ;
                     cnt_q       <= '0;
                     sram_en     <= 1'b1;
                     sram_be     <= lane_be;
                     sram_addr   <= req_addr[ADDR_WIDTH-1:2];
                     sram_wdata  <= lane_wdata;
                     ld_funct3_q <= req_funct3;
                     ld_off_q    <= req_addr[1:0];
                  end else begin
                     misalign   <= 1'b1;
                     resp_rdata <= '0;
                  end
               end
            end
            DM_REQ: begin
               // Ready takes priority over a timeout expiring in the same cycle.
               if (sram_ready) begin
                  resp_rdata <= lane_rdata;
                  sram_en    <= 1'b0;
                  state_q    <= DM_RESP;
               end else if (cnt_q == TimeoutLast) begin
                  resp_rdata <= '0;
                  bus_err    <= 1'b1;
                  sram_en    <= 1'b0;
                  state_q    <= DM_RESP;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            DM_RESP: begin
               state_q <= DM_IDLE;
            end
            default: begin
               state_q <= DM_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: vector table with a response scoreboard,
// plus hand-written reset sequences.
module tb_dmem_ctrl;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [31:0] resp_rdata;
   logic        stall;
   logic        misalign;
   logic        bus_err;
   logic        sram_en;
   logic [3:0]  sram_be;
   logic [29:0] sram_addr;
   logic [31:0] sram_wdata;
   logic [31:0] sram_rdata;
   logic        sram_ready;

   int checks = 0;
   int failures = 0;

   dmem_ctrl #(
      .DATA_WIDTH (32),
      .ADDR_WIDTH (32),
      .TIMEOUT    (TO)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_we     (req_we),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_rdata (resp_rdata),
      .stall      (stall),
      .misalign   (misalign),
      .bus_err    (bus_err),
      .sram_en    (sram_en),
      .sram_be    (sram_be),
      .sram_addr  (sram_addr),
      .sram_wdata (sram_wdata),
      .sram_rdata (sram_rdata),
      .sram_ready (sram_ready)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          nready;  // REQ cycle on which ready is driven; 0 = never
      logic        mis;
      logic [29:0] e_addr;
      logic [3:0]  e_be;
      logic [31:0] e_wdata;
      logic [31:0] e_rdata;
      logic        e_berr;
   } vec_t;

   vec_t        tbl[$];
   logic [32:0] sb[$];

   function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [31:0] rdata,
                               input int nready, input logic mis, input logic [29:0] e_addr,
                               input logic [3:0] e_be, input logic [31:0] e_wdata,
                               input logic [31:0] e_rdata, input logic e_berr);
      vec_t v;
      v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
      v.nready = nready; v.mis = mis; v.e_addr = e_addr; v.e_be = e_be;
      v.e_wdata = e_wdata; v.e_rdata = e_rdata; v.e_berr = e_berr;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic run_vec(input vec_t v);
      int          n;
      int          stalls;
      int          exp_stalls;
      logic [32:0] e;
      @(posedge clk); #1;
      req_valid  = 1'b1;
      req_we     = v.we;
      req_funct3 = v.f3;
      req_addr   = v.addr;
      req_wdata  = v.wdata;
      sram_rdata = v.rdata;
      sram_ready = 1'b0;
      @(negedge clk);
      if (v.mis) begin
         chk("mis_stall", 32'(stall), 32'd0);
         chk("mis_en", 32'(sram_en), 32'd0);
         @(posedge clk); #1;
         req_valid = 1'b0;
         @(negedge clk);
         chk("mis_pulse", 32'(misalign), 32'd1);
         chk("mis_no_en", 32'(sram_en), 32'd0);
         chk("mis_rdata", resp_rdata, 32'd0);
         chk("mis_no_berr", 32'(bus_err), 32'd0);
         @(posedge clk); #1;
         @(negedge clk);
         chk("mis_once", 32'(misalign), 32'd0);
         chk("mis_idle_en", 32'(sram_en), 32'd0);
         return;
      end
      chk("stall_comb", 32'(stall), 32'd1);
      sb.push_back({v.e_berr, v.e_rdata});
      stalls = 1;
      n = 0;
      while (1) begin
         @(posedge clk); #1;
         n++;
         sram_ready = (n == v.nready);
         @(negedge clk);
         if (!stall) break;
         stalls++;
         chk("req_en", 32'(sram_en), 32'd1);
         chk("req_addr", 32'(sram_addr), 32'(v.e_addr));
         chk("req_be", 32'(sram_be), 32'(v.e_be));
         if (n == 1) chk("req_wdata", sram_wdata, v.e_wdata);
         if (n > 40) begin
            chk("req_bound", 32'(stall), 32'd0);
            break;
         end
      end
      exp_stalls = (v.nready == 0 || v.nready > TO) ? TO + 1 : v.nready + 1;
      chk("stall_cycles", 32'(stalls), 32'(exp_stalls));
      chk("resp_en_low", 32'(sram_en), 32'd0);
      if (sb.size() == 0) begin
         chk("sb_empty", 32'd0, 32'd1);
      end else begin
         e = sb.pop_front();
         chk("resp_berr", 32'(bus_err), 32'(e[32]));
         if (!v.we) chk("resp_rdata", resp_rdata, e[31:0]);
      end
      // Request still held through RESP; it must not be relaunched.
      @(posedge clk); #1;
      req_valid  = 1'b0;
      sram_ready = 1'b0;
      @(negedge clk);
      chk("no_relaunch", 32'(sram_en), 32'd0);
      chk("berr_once", 32'(bus_err), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n      = 1'b0;
      req_valid  = 1'b1;
      req_we     = 1'b0;
      req_funct3 = 3'b010;
      req_addr   = 32'h0;
      req_wdata  = 32'h0;
      sram_rdata = 32'h0;
      sram_ready = 1'b0;
      #12;
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_en", 32'(sram_en), 32'd0);
      chk("rst_be", 32'(sram_be), 32'd0);
      chk("rst_addr", 32'(sram_addr), 32'd0);
      chk("rst_wdata", sram_wdata, 32'd0);
      chk("rst_rdata", resp_rdata, 32'd0);
      chk("rst_flags", {30'd0, misalign, bus_err}, 32'd0);
      req_valid = 1'b0;
      #5 rst_n = 1'b1;

      tbl.push_back(mk(1, 3'b000, 32'h1003, 32'h000000AB, 32'h0, 1, 0, 30'h400, 4'b1000, 32'hABABABAB, 32'h0, 0));
      tbl.push_back(mk(0, 3'b000, 32'h1002, 32'h0, 32'h00800000, 1, 0, 30'h400, 4'b0000, 32'h0, 32'hFFFFFF80, 0));
      tbl.push_back(mk(0, 3'b100, 32'h1002, 32'h0, 32'h00800000, 1, 0, 30'h400, 4'b0000, 32'h0, 32'h00000080, 0));
      tbl.push_back(mk(0, 3'b001, 32'h2002, 32'h0, 32'h80011234, 3, 0, 30'h800, 4'b0000, 32'h0, 32'hFFFF8001, 0));
      tbl.push_back(mk(0, 3'b101, 32'h2002, 32'h0, 32'h80011234, 2, 0, 30'h800, 4'b0000, 32'h0, 32'h00008001, 0));
      tbl.push_back(mk(0, 3'b010, 32'h1001, 32'h0, 32'h0, 0, 1, 30'h0, 4'b0000, 32'h0, 32'h0, 0));
      tbl.push_back(mk(0, 3'b001, 32'h1001, 32'h0, 32'h0, 0, 1, 30'h0, 4'b0000, 32'h0, 32'h0, 0));
      tbl.push_back(mk(1, 3'b010, 32'h0002, 32'h0, 32'h0, 0, 1, 30'h0, 4'b0000, 32'h0, 32'h0, 0));
      tbl.push_back(mk(0, 3'b010, 32'h3000, 32'h0, 32'h12345678, 0, 0, 30'hC00, 4'b0000, 32'h0, 32'h0, 1));
      tbl.push_back(mk(1, 3'b001, 32'h0006, 32'h1234BEEF, 32'h0, 1, 0, 30'h1, 4'b1100, 32'hBEEFBEEF, 32'h0, 0));
      tbl.push_back(mk(1, 3'b000, 32'h0005, 32'h00000077, 32'h0, 2, 0, 30'h1, 4'b0010, 32'h77777777, 32'h0, 0));
      tbl.push_back(mk(1, 3'b010, 32'h0008, 32'hDEADBEEF, 32'h0, 4, 0, 30'h2, 4'b1111, 32'hDEADBEEF, 32'h0, 0));
      tbl.push_back(mk(0, 3'b010, 32'h0010, 32'h0, 32'h12345678, 2, 0, 30'h4, 4'b0000, 32'h0, 32'h12345678, 0));
      tbl.push_back(mk(0, 3'b000, 32'h0011, 32'h0, 32'h0000F500, 1, 0, 30'h4, 4'b0000, 32'h0, 32'hFFFFFFF5, 0));
      tbl.push_back(mk(0, 3'b011, 32'h0014, 32'h0, 32'hCAFEBABE, 1, 0, 30'h5, 4'b0000, 32'h0, 32'hCAFEBABE, 0));
      tbl.push_back(mk(0, 3'b110, 32'h0018, 32'h0, 32'h80000001, 1, 0, 30'h6, 4'b0000, 32'h0, 32'h80000001, 0));
      tbl.push_back(mk(1, 3'b111, 32'h001C, 32'h11223344, 32'h0, 1, 0, 30'h7, 4'b1111, 32'h11223344, 32'h0, 0));
      tbl.push_back(mk(0, 3'b100, 32'h1003, 32'h0, 32'h9A000000, 1, 0, 30'h400, 4'b0000, 32'h0, 32'h0000009A, 0));
      tbl.push_back(mk(0, 3'b001, 32'h0000, 32'h0, 32'h0000FFFE, 2, 0, 30'h0, 4'b0000, 32'h0, 32'hFFFFFFFE, 0));
      tbl.push_back(mk(0, 3'b101, 32'h0000, 32'h0, 32'hFFFF7FFF, 1, 0, 30'h0, 4'b0000, 32'h0, 32'h00007FFF, 0));

      foreach (tbl[i]) run_vec(tbl[i]);

      // Reset mid-access: sram_en and stall must drop without waiting for a clock.
      @(posedge clk); #1;
      req_valid  = 1'b1;
      req_we     = 1'b0;
      req_funct3 = 3'b010;
      req_addr   = 32'h0040;
      sram_ready = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      chk("mid_en_before", 32'(sram_en), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_en", 32'(sram_en), 32'd0);
      chk("mid_rst_stall", 32'(stall), 32'd0);
      @(posedge clk); #1;
      req_valid = 1'b0;
      #3 rst_n = 1'b1;

      run_vec(mk(1, 3'b010, 32'h0000, 32'h55AA55AA, 32'h0, 1, 0, 30'h0, 4'b1111, 32'h55AA55AA, 32'h0, 0));
      chk("sb_drained", 32'(sb.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
